// File: rtl/z_sine_plotter_pkg.sv
// z_sine_plotter_pkg
//   Shared constants for the sine plotter: default plot geometry, the RGB565
//   colour table, the phase-step table selected by the period count, and the
//   small types used to carry pixel control information down the pipeline.
package z_sine_plotter_pkg;

  // Default screen / plot geometry (overridable via module parameters)
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_PLOT_Y0  = 8;
  localparam int DEF_PLOT_Y1  = 263;
  localparam int DEF_AXIS_ROW = 128;

  // Colour table (RGB565)
  localparam logic [15:0] BLACK      = 16'h0000;
  localparam logic [15:0] WAVE_GREEN = 16'h07E0;
  localparam logic [15:0] AXIS_GRAY  = 16'h8410;

  // Largest legal "periods minus one" value; anything above is treated as this
  localparam logic [2:0] MAX_PERIOD_IDX = 3'd4;

  // Colour decision made in the last pipeline stage
  typedef enum logic [1:0] {
    PIX_BLACK = 2'd0,
    PIX_WAVE  = 2'd1,
    PIX_AXIS  = 2'd2
  } pix_class_e;

  // Per-pixel control carried alongside the phase through the pipeline
  typedef struct packed {
    logic       de;         // pixel valid
    logic       draw;       // line is being drawn (enabled and started at x=0)
    logic       in_plot;    // inside plot rows and visible columns
    logic       first_col;  // x == 0, previous sample is not available
    logic [7:0] row;        // row offset measured up from the last plot row
  } pix_ctl_t;

  function automatic logic [2:0] clamp_periods(input logic [2:0] p);
    return (p > MAX_PERIOD_IDX) ? MAX_PERIOD_IDX : p;
  endfunction

  // round(N*65536/480) for N = p+1 sine periods across the visible width
  function automatic logic [15:0] phase_step(input logic [2:0] p);
    logic [15:0] s;
    case (p)
      3'd0:    s = 16'd137;
      3'd1:    s = 16'd273;
      3'd2:    s = 16'd410;
      3'd3:    s = 16'd546;
      default: s = 16'd683;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/z_sine_rom.sv
// z_sine_rom
//   256x8 sine table, value(a) = round(127.5 + 127.5*sin(2*pi*a/256)),
//   registered output (one cycle of read latency).
//   Ports:
//     clk     in   clock
//     rst_n   in   asynchronous active-low reset (clears the output register)
//     i_addr  in   8-bit table address
//     o_data  out  8-bit sample, valid one cycle after i_addr
module z_sine_rom
  import z_sine_plotter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_addr,
  output logic [7:0] o_data
);

  // floor(127.5*sin(pi*k/128)) for k = 0..64 (first quarter wave)
  function automatic logic [6:0] quarter(input logic [6:0] k);
    logic [6:0] q;
    case (k)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd15;  7'd6:  q = 7'd18;  7'd7:  q = 7'd21;
      7'd8:  q = 7'd24;  7'd9:  q = 7'd27;  7'd10: q = 7'd30;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd39;  7'd14: q = 7'd42;  7'd15: q = 7'd45;
      7'd16: q = 7'd48;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd62;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd70;  7'd25: q = 7'd73;  7'd26: q = 7'd75;  7'd27: q = 7'd78;
      7'd28: q = 7'd80;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd87;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd110;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126;
      default: q = 7'd127;
    endcase
    return q;
  endfunction

  // Rebuild the full wave from the quarter table. Rounding 127.5+y equals
  // 128+floor(y), so the negative half is 127-q except at exactly zero
  // crossing (address 128), where the result is 128 rather than 127.
  function automatic logic [7:0] sine_value(input logic [7:0] a);
    logic [6:0] m;
    logic [6:0] k;
    logic [6:0] q;
    logic [7:0] v;
    m = a[6:0];
    k = (m > 7'd64) ? (7'd0 - m) : m;
    q = quarter(k);
    if (!a[7]) begin
      v = 8'd128 + {1'b0, q};
    end else if (m == 7'd0) begin
      v = 8'd128;
    end else begin
      v = 8'd127 - {1'b0, q};
    end
    return v;
  endfunction

  // Synchronous read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= 8'd0;
    end else begin
      o_data <= sine_value(i_addr);
    end
  end

endmodule

// File: rtl/z_sine_plotter.sv
// z_sine_plotter
//   Draws 1..5 sine periods across the LCD plot area. Three pipeline stages:
//   S1 registers phase and pixel coordinates, S2 reads the sine ROM, S3
//   compares the row offset against the current/previous sample and picks
//   the colour. Vertical gaps between adjacent columns are filled so the
//   curve is continuous.
//   Ports:
//     clk                  in   pixel clock
//     rst_n                in   asynchronous active-low reset
//     en                   in   block enable
//     iActive_Periods_Num  in   periods to draw minus one, latched on iVSync
//     iVSync               in   start-of-frame pulse
//     iDE, iX, iY          in   pixel valid and coordinates
//     oDE                  out  iDE delayed by 3 cycles
//     oRGB565              out  pixel colour, aligned with oDE
module z_sine_plotter
  import z_sine_plotter_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int PLOT_Y0  = DEF_PLOT_Y0,
  parameter int PLOT_Y1  = DEF_PLOT_Y1,
  parameter int AXIS_ROW = DEF_AXIS_ROW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  iActive_Periods_Num,
  input  logic        iVSync,
  input  logic        iDE,
  input  logic [9:0]  iX,
  input  logic [9:0]  iY,
  output logic        oDE,
  output logic [15:0] oRGB565
);

  localparam logic [9:0] X_LIMIT   = 10'(H_ACTIVE);
  localparam logic [9:0] Y_FIRST   = 10'(PLOT_Y0);
  localparam logic [9:0] Y_LAST    = 10'(PLOT_Y1);
  localparam logic [7:0] Y_LAST_LO = 8'(PLOT_Y1);
  localparam logic [7:0] AXIS_R    = 8'(AXIS_ROW);

  logic [2:0]  r_periods;
  logic        r_armed;
  logic [15:0] r_acc;
  pix_ctl_t    r_s1;
  pix_ctl_t    r_s2;
  logic [7:0]  r_prev;

  logic [2:0]  w_periods;
  logic [15:0] w_step;
  logic        w_line_start;
  pix_ctl_t    w_s1_next;
  logic [7:0]  w_cur;
  logic [7:0]  w_prev;
  logic [7:0]  w_lo;
  logic [7:0]  w_hi;
  pix_class_e  w_class;

  // Input decode. A period value arriving with iVSync is used immediately,
  // so a pixel coincident with the frame pulse already sees the new step.
  // The row offset is taken mod 256; it only matters inside the plot rows.
  always_comb begin
    w_periods           = iVSync ? clamp_periods(iActive_Periods_Num) : r_periods;
    w_step              = phase_step(w_periods);
    w_line_start        = iDE && (iX == 10'd0);
    w_s1_next.de        = iDE;
    w_s1_next.draw      = en && iDE && (w_line_start || r_armed);
    w_s1_next.in_plot   = (iY >= Y_FIRST) && (iY <= Y_LAST) && (iX < X_LIMIT);
    w_s1_next.first_col = (iX == 10'd0);
    w_s1_next.row       = Y_LAST_LO - iY[7:0];
  end

  // Period latch and phase accumulator (S1 phase). r_armed marks that the
  // current line started at x=0 while enabled; without it a line entered
  // mid-way (after reset or re-enable) stays background until the next x=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_periods <= 3'd0;
      r_armed   <= 1'b0;
      r_acc     <= 16'd0;
    end else begin
      if (iVSync) begin
        r_periods <= w_periods;
      end
      if (!en) begin
        r_acc   <= 16'd0;
        r_armed <= 1'b0;
      end else if (w_line_start) begin
        r_acc   <= 16'd0;
        r_armed <= 1'b1;
      end else if (iDE && r_armed) begin
        r_acc <= r_acc + w_step;
      end
    end
  end

  // Control pipeline, kept in step with the ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_s1_next;
      r_s2 <= r_s1;
    end
  end

  z_sine_rom u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_addr (r_acc[15:8]),
    .o_data (w_cur)
  );

  // Colour decision: the wave covers every row between the previous and
  // current column's sample so steep slopes have no gaps.
  always_comb begin
    w_prev  = r_s2.first_col ? w_cur : r_prev;
    w_lo    = (w_prev < w_cur) ? w_prev : w_cur;
    w_hi    = (w_prev < w_cur) ? w_cur : w_prev;
    w_class = PIX_BLACK;
    if (r_s2.de && r_s2.draw && r_s2.in_plot) begin
      if ((r_s2.row >= w_lo) && (r_s2.row <= w_hi)) begin
        w_class = PIX_WAVE;
      end else if (r_s2.row == AXIS_R) begin
        w_class = PIX_AXIS;
      end
    end
  end

  // S3 output register and previous-column sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 8'd0;
      oDE     <= 1'b0;
      oRGB565 <= BLACK;
    end else begin
      if (r_s2.de) begin
        r_prev <= w_cur;
      end
      oDE <= r_s2.de;
      case (w_class)
        PIX_WAVE: oRGB565 <= WAVE_GREEN;
        PIX_AXIS: oRGB565 <= AXIS_GRAY;
        default:  oRGB565 <= BLACK;
      endcase
    end
  end

endmodule

// File: tb/tb_z_sine_plotter.sv
// tb_z_sine_plotter
//   Directed plus randomized stimulus for z_sine_plotter. Expected pixels
//   are computed from the plotting rules directly (phase = x*step, samples
//   from $sin) and compared three cycles later.
module tb_z_sine_plotter;

  localparam logic [15:0] C_BLACK = 16'h0000;
  localparam logic [15:0] C_GREEN = 16'h07E0;
  localparam logic [15:0] C_GRAY  = 16'h8410;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  per = 3'd0;
  logic        vs = 1'b0;
  logic        de = 1'b0;
  logic [9:0]  x = 10'd0;
  logic [9:0]  y = 10'd0;
  logic        oDE;
  logic [15:0] oRGB565;

  int nVectors = 0;
  int nMiscompares = 0;
  int cycleNo = 0;
  int mPeriods = 0;
  bit mArmed = 1'b0;

  typedef struct {
    bit          de;
    logic [15:0] rgb;
  } exp_t;
  exp_t expQ[$];

  z_sine_plotter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .iActive_Periods_Num (per),
    .iVSync              (vs),
    .iDE                 (de),
    .iX                  (x),
    .iY                  (y),
    .oDE                 (oDE),
    .oRGB565             (oRGB565)
  );

  always #5 clk = ~clk;

  // Ideal sine sample, round half up of 127.5 + 127.5*sin
  function automatic int romRef(int a);
    real v;
    v = 128.0 + 127.5 * $sin(2.0 * 3.14159265358979 * a / 256.0);
    return $rtoi($floor(v));
  endfunction

  function automatic int stepRef(int p);
    return $rtoi((p + 1) * 65536.0 / 480.0 + 0.5);
  endfunction

  function automatic logic [15:0] colourRef(bit draw, bit d, int px, int py, int step);
    int r, cur, prev, lo, hi;
    if (!draw || !d || py < 8 || py > 263 || px >= 480) return C_BLACK;
    r    = 263 - py;
    cur  = romRef(((px * step) % 65536) / 256);
    prev = (px == 0) ? cur : romRef((((px - 1) * step) % 65536) / 256);
    lo   = (prev < cur) ? prev : cur;
    hi   = (prev < cur) ? cur : prev;
    if (r >= lo && r <= hi) return C_GREEN;
    if (r == 128) return C_GRAY;
    return C_BLACK;
  endfunction

  task automatic checkOutput(string tag, logic [15:0] expRgb, bit expDe);
    nVectors++;
    assert (oDE === expDe) else begin
      nMiscompares++;
      $error("[TB] FAIL %s oDE at vector %0d: got %b want %b", tag, cycleNo, oDE, expDe);
    end
    nVectors++;
    assert (oRGB565 === expRgb) else begin
      nMiscompares++;
      $error("[TB] FAIL %s oRGB565 at vector %0d: got %h want %h", tag, cycleNo, oRGB565, expRgb);
    end
  endtask

  // One pixel clock: check the output due now, then drive the next input
  task automatic applyStimulus(bit e, int p, bit v, bit d, int px, int py);
    exp_t ex;
    bit   draw;
    int   step;
    @(negedge clk);
    ex = expQ.pop_front();
    checkOutput("pipe", ex.rgb, ex.de);
    en  = e;
    per = p[2:0];
    vs  = v;
    de  = d;
    x   = px[9:0];
    y   = py[9:0];
    if (v) mPeriods = (p > 4) ? 4 : p;
    step = stepRef(mPeriods);
    draw = e && d && (px == 0 || mArmed);
    if (!e) mArmed = 1'b0;
    else if (d && px == 0) mArmed = 1'b1;
    ex.de  = d;
    ex.rgb = colourRef(draw, d, px, py, step);
    expQ.push_back(ex);
    cycleNo++;
  endtask

  task automatic driveLine(bit e, int p, bit vsAtStart, int py, int lastX, int blank);
    for (int i = 0; i <= lastX; i++) applyStimulus(e, p, vsAtStart && (i == 0), 1'b1, i, py);
    for (int i = 0; i < blank; i++) applyStimulus(e, p, 1'b0, 1'b0, int'($urandom_range(0, 1023)), py);
  endtask

  task automatic doReset(int cycles);
    exp_t ex;
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1; vs = 1'b0; de = 1'b0; per = 3'd0;
    expQ.delete();
    mArmed = 1'b0;
    mPeriods = 0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      checkOutput("reset", C_BLACK, 1'b0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    ex.de = 1'b0;
    ex.rgb = C_BLACK;
    repeat (3) expQ.push_back(ex);
  endtask

  initial begin
    int p, vmode, dropA, dropB, py;
    doReset(3);

    // First pixel of a line on the axis row: wave at exactly 3 cycles
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 135);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
    nVectors++;
    assert (oRGB565 === C_GREEN && oDE === 1'b1) else begin
      nMiscompares++;
      $error("[TB] FAIL first_pixel: got de=%b rgb=%h want de=1 rgb=%h", oDE, oRGB565, C_GREEN);
    end

    // One period per line
    driveLine(1, 0, 0, 135, 479, 6);
    driveLine(1, 0, 0, 136, 479, 6);
    driveLine(1, 0, 0, int'($urandom_range(8, 263)), 479, 6);

    // Period input changes mid-frame: still one period until the next frame
    driveLine(1, 4, 0, 100, 479, 6);
    driveLine(1, 4, 0, 8, 479, 6);
    applyStimulus(1, 4, 1, 0, 0, 0);
    driveLine(1, 4, 0, 200, 479, 6);
    driveLine(1, 4, 0, 263, 483, 6);

    // Out-of-range period value clamps; rows outside the plot stay black
    applyStimulus(1, 6, 1, 0, 0, 0);
    driveLine(1, 6, 0, 4, 479, 4);
    driveLine(1, 6, 0, 270, 479, 4);
    driveLine(1, 6, 0, 7, 479, 4);
    driveLine(1, 6, 0, 264, 479, 4);
    driveLine(1, 6, 0, 60, 479, 4);

    // Frame pulse coincident with the first pixel of a line
    driveLine(1, 1, 1, 150, 479, 6);

    // Enable dropped mid-line, then a fully disabled line, then recovery
    for (int i = 0; i < 480; i++) applyStimulus(!(i >= 200 && i < 260), 1, 0, 1, i, 120);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0, 120);
    driveLine(0, 1, 0, 121, 479, 6);
    driveLine(1, 1, 0, 122, 479, 6);

    // Reset in the middle of a line
    for (int i = 0; i < 240; i++) applyStimulus(1, 1, 0, 1, i, 128);
    doReset(2);
    for (int i = 240; i < 480; i++) applyStimulus(1, 1, 0, 1, i, 128);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0, 128);
    driveLine(1, 1, 0, 130, 479, 6);

    // Randomized lines
    for (int l = 0; l < 20; l++) begin
      p     = int'($urandom_range(0, 7));
      vmode = int'($urandom_range(0, 3));
      py    = int'($urandom_range(0, 271));
      dropA = 1000;
      dropB = 1000;
      if ($urandom_range(0, 3) == 0) begin
        dropA = int'($urandom_range(0, 400));
        dropB = dropA + int'($urandom_range(1, 60));
      end
      if (vmode == 1) applyStimulus(1, p, 1, 0, 0, py);
      for (int i = 0; i < 480; i++)
        applyStimulus(!(i >= dropA && i < dropB), p, (vmode == 2) && (i == 0), 1, i, py);
      for (int i = 0; i < int'($urandom_range(2, 10)); i++)
        applyStimulus(1, p, 0, 0, int'($urandom_range(0, 1023)), py);
    end

    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
